// File: rtl/uart_rx.sv
// 8N1 serial receiver (optional even parity via UART_RX_PARITY_EN) with a
// 2-flop input synchronizer, registered status strobes and FSM debug outputs.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       Serial_Data,
  output logic [7:0] Output_Data,
  output logic       Data_Valid,
  output logic       Framing_Error,
  output logic       Parity_Error,
  output logic [1:0] State,
  output logic       sm_Transition_Flag
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [3:0]    BIT_LAST = 4'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    out_q, out_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          flag_q, flag_d;
  logic          par_ok_s;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  assign par_ok_s = (even_parity(shift_q) == par_q);
`else
  assign par_ok_s = 1'b1;
`endif

  // Next-state and strobe generation
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = 4'd0;
        if (sync2_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 4'd8) begin
            par_d = sync2_q;
          end else begin
            shift_d = {sync2_q, shift_q[7:1]};
          end
`else
          shift_d = {sync2_q, shift_q[7:1]};
`endif
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = 4'd0;
          state_d = S_IDLE;
          if (!sync2_q) begin
            // Break or bad stop: disarm until the line goes high again
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end else if (par_ok_s) begin
            out_d   = shift_q;
            valid_d = 1'b1;
          end else begin
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    flag_d = (state_d != state_q);
  end

  // State, datapath and output registers
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shift_q <= 8'd0;
      out_q   <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      flag_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= Serial_Data;
      sync2_q <= sync1_q;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      flag_q  <= flag_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign Output_Data        = out_q;
  assign Data_Valid         = valid_q;
  assign Framing_Error      = ferr_q;
  assign State              = state_q;
  assign sm_Transition_Flag = flag_q;
`ifdef UART_RX_PARITY_EN
  assign Parity_Error = perr_q;
`else
  assign Parity_Error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=8; frames queue their expected
// strobe (kind, data, cycle) and a forked monitor checks each strobe it sees.
module tb_uart_rx;
  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NDATA = 9;
`else
  localparam int NDATA = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line = 1'b1;
  logic [7:0] out_data;
  logic       dv, fe, pe, tflag;
  logic [1:0] state;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50          (clk),
    .Reset             (rst),
    .Serial_Data       (line),
    .Output_Data       (out_data),
    .Data_Valid        (dv),
    .Framing_Error     (fe),
    .Parity_Error      (pe),
    .State             (state),
    .sm_Transition_Flag(tflag)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic last_rst = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_rst <= rst;
  end

  typedef struct {
    int         kind;   // 0 valid, 1 framing, 2 parity
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_out = 8'h00;
  bit         saw_nonidle = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [1:0] prev_state = 2'd0;
    exp_t       e;
    int         kind_act;
    forever begin
      @(negedge clk);
      if (!last_rst) chk("transition_flag", int'(tflag), int'(state != prev_state));
      prev_state = state;
      if (state != 2'd0) saw_nonidle = 1'b1;
      if (dv || fe || pe) begin
        chk("strobes_exclusive", int'(dv) + int'(fe) + int'(pe), 1);
        kind_act = dv ? 0 : (fe ? 1 : 2);
        if (sbq.size() == 0) begin
          chk("unexpected_strobe_kind", kind_act, -1);
        end else begin
          e = sbq.pop_front();
          chk("strobe_kind", kind_act, e.kind);
          chk("strobe_data", int'(out_data), int'(e.data));
          chk("strobe_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
    logic [11:0] bits;
    int          nb;
    exp_t        e;
    bits      = 12'h000;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ bad_par;
    bits[10] = stop_b;
    nb       = 11;
`else
    bits[9] = stop_b;
    nb      = 10;
`endif
    // start edge captured at cyc+1, entry to START two edges later
    e.cyc = cyc + 3 + HALF + (NDATA + 1) * CPB;
    if (!stop_b) begin
      e.kind = 1;
      e.data = exp_out;
    end else if (bad_par) begin
      e.kind = 2;
      e.data = exp_out;
    end else begin
      e.kind  = 0;
      e.data  = d;
      exp_out = d;
    end
    sbq.push_back(e);
    for (int i = 0; i < nb; i++) begin
      line = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] abort_d;
    fork
      monitor();
    join_none

    rst  = 1'b1;
    line = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_data", int'(out_data), 0);
    chk("reset_strobes", int'({dv, fe, pe}), 0);
    chk("reset_flag", int'(tflag), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    send_frame(8'h41, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // 3-cycle glitch must start and then abandon a frame
    saw_nonidle = 1'b0;
    line = 1'b0;
    repeat (3) @(posedge clk);
    #1 line = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_saw_start", int'(saw_nonidle), 1);
    chk("glitch_state", int'(state), 0);
    chk("glitch_data", int'(out_data), 8'h41);

    // bad stop bit followed by a held-low break
    send_frame(8'h55, 1'b0, 1'b0);
    saw_nonidle = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("break_no_retrigger", int'(saw_nonidle), 0);
    chk("break_data", int'(out_data), 8'h41);
    line = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // reset in the middle of data bit 3
    abort_d = 8'h5A;
    line = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 line = abort_d[i];
      repeat (CPB) @(posedge clk);
    end
    #1;
    chk("abort_in_data", int'(state), 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_reset_state", int'(state), 0);
    chk("abort_reset_data", int'(out_data), 0);
    rst     = 1'b0;
    line    = 1'b1;
    exp_out = 8'h00;
    repeat (10) @(posedge clk);
    #1;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
`endif

    repeat (20) @(posedge clk);
    #1;
    chk("final_data", int'(out_data), int'(exp_out));
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the team's `UART_TX`: recovers 8-bit frames (1 start, 8 data LSB-first, optional parity, 1 stop) from the serial audio line and presents each byte with a one-cycle valid strobe. Sits at the receive end of the serial audio link, clocked from the 50 MHz system clock, feeding the sample reassembly logic. Exposes its FSM state and a transition strobe for debug, mirroring the transmitter.

## Interface
- `CLKS_PER_BIT`, 434, CLOCK_50 cycles per bit (115200 baud); must be ≥ 4.
- `CLOCK_50`  input  1  system clock; all logic on rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `Serial_Data`  input  1  asynchronous serial line, idle high.
- `Output_Data`  output  8  last good received byte.
- `Data_Valid`  output  1  one-cycle strobe: `Output_Data` updated this cycle.
- `Framing_Error`  output  1  one-cycle strobe: stop bit sampled low.
- `Parity_Error`  output  1  one-cycle strobe: parity mismatch (tied 0 without parity).
- `State`  output  2  current FSM state.
- `sm_Transition_Flag`  output  1  high for one cycle after any `State` change.

## Operation
- `Serial_Data` passes a 2-flop synchronizer (both flops reset to 1); FSM uses the second flop only.
- States: IDLE=0, START=1, DATA=2, STOP=3.
- IDLE: `armed` set whenever synced line is high; synced low with `armed` set → START, counter=0.
- START: counter counts to HALF−1 (HALF = CLKS_PER_BIT/2, truncated); on that cycle, line low → DATA, counter=0; line high → IDLE (glitch, nothing reported).
- DATA: counter counts 0..CLKS_PER_BIT−1; at terminal count sample line into shift register (LSB first), counter=0, bit index+1. After 8 bits (9 with parity) → STOP.
- STOP: at terminal count sample line. High: parity OK → `Output_Data` ← shift register, `Data_Valid`=1; parity bad → `Parity_Error`=1, `Output_Data` unchanged. Low: `Framing_Error`=1, `Output_Data` unchanged, `armed` cleared. Always → IDLE.
- Strobes are registered, mutually exclusive, one cycle wide.
- `armed` cleared by framing error; a held-low line (break) never re-triggers until it returns high.
- Reset (any state, any cycle): State=IDLE, counters/bit index=0, shift register=0, `Output_Data`=0, all strobes 0, `sm_Transition_Flag`=0, synchronizer=1, `armed`=0.

## Timing
- Let t0 be the edge at which the first synchronizer flop first captures 0. FSM enters START at edge t0+2.
- START decision at edge t0+2+HALF; data bit k (0..7) sampled at edge t0+2+HALF+(k+1)·CLKS_PER_BIT.
- Stop bit sampled at edge t0+2+HALF+9·CLKS_PER_BIT (10· with parity); `Data_Valid`/error strobe high during the following cycle.
- Back-to-back frames with zero idle time are received without loss (start edge arrives ≥ HALF cycles after stop sample).
- `sm_Transition_Flag` high the cycle after each edge that changes `State`.

## Configuration
- `UART_RX_PARITY_EN` defined: 9th DATA bit is even parity over the 8 data bits; mismatch → `Parity_Error`, no `Data_Valid`.
- Undefined: 8 DATA bits, `Parity_Error` constant 0, frame timing as above without parity term.

## Test plan
- CLKS_PER_BIT=8, send 0x41 with valid stop → `Output_Data`=0x41, single-cycle `Data_Valid` at t0+2+4+72+1, no error strobes.
- 3-cycle low glitch on idle line → START then IDLE, no strobes, `Output_Data` unchanged.
- Send 0x55 with stop bit low, line held low 40 cycles → one `Framing_Error` pulse, `Output_Data` stays 0x41, no re-entry to START until line high.
- Assert `Reset` during DATA bit 3 → next cycle State=0, `Output_Data`=0; following frame 0xA5 received as 0xA5.
- Back-to-back 0x00 then 0xFF, no idle gap → two `Data_Valid` pulses 10·CLKS_PER_BIT apart, values 0x00, 0xFF.
- With `UART_RX_PARITY_EN`: 0x41, parity bit 0 → `Data_Valid`, 0x41; parity bit 1 → `Parity_Error` pulse, no `Data_Valid`.
